alu_seq_param: RTL and testbench
================================

Name: alu_seq_param

Overview:
- Parametrised, registered successor to the team's 8-bit combinational ALU: same 16-opcode command set, operand width set by WIDTH.
- Start/busy/done handshake added. Single-cycle ops take 1 cycle; MUL and DIV are iterative multi-cycle ops (shift-add multiply, restoring divide).
- Result and flags (zero, carry, div_err) are held in registers.
- Sits between the datapath register file and the writeback mux.

Parameters:
- WIDTH, 8, operand width in bits. Must be ≥ 2. Result width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- command_in  input  4  opcode, latched with start
- a_in  input  WIDTH  operand A, latched with start
- b_in  input  WIDTH  operand B, latched with start
- oe  input  1  output enable; d_out = oe ? result_reg : 0 (combinational gate, no tri-state)
- busy  output  1  high while a multi-cycle op iterates
- done  output  1  one-cycle pulse; result and flags are valid and updated
- d_out  output  2*WIDTH  result
- zero  output  1  result_reg == 0 over all 2*WIDTH bits
- carry  output  1  carry/borrow/shifted-out bit of the last op
- div_err  output  1  last op was DIV with b == 0

Behaviour:
- Reset (async): state = IDLE; busy, done, result_reg, zero, carry, div_err, iteration counter all cleared to 0.
- FSM states:
  - IDLE: if start, latch operands and opcode. MUL/DIV with b ≠ 0 go to ITER; every other op, including DIV by 0, goes to FIN.
  - ITER: busy = 1. One iteration per cycle, counter runs 0 .. WIDTH-1. When counter = WIDTH-1, go to FIN.
  - FIN: write result_reg and flags, pulse done, return to IDLE.
- Latency, with start sampled at edge N:
  - Single-cycle ops: done high after edge N+1.
  - MUL/DIV: busy high after edges N+1 .. N+WIDTH; done high after edge N+WIDTH+1.
- start outside IDLE (ITER or FIN) is ignored; no queueing.
- Back-to-back: start asserted while done is high is accepted, because the FSM is already in IDLE.
- result_reg and flags hold their value between done pulses. d_out tracks oe combinationally.
- Opcodes (r = result, W = WIDTH, all results zero-extended to 2W):
  - 0 ADD: r = a+b in W+1 bits; carry = r[W].
  - 1 INC: r = a+1 in W+1 bits; carry = r[W].
  - 2 SUB: r[W-1:0] = a-b mod 2^W; carry = borrow (a < b); r[W] = borrow.
  - 3 DEC: r[W-1:0] = a-1 mod 2^W; carry = borrow (a == 0); r[W] = borrow.
  - 4 MUL: unsigned full product, 2W bits; carry = 0.
  - 5 DIV: r[W-1:0] = quotient, r[2W-1:W] = remainder.
    - b == 0: quotient = all ones, remainder = a, div_err = 1, latency of a single-cycle op.
  - 6 SHL: r = {a,0} in W+1 bits; carry = a[W-1].
  - 7 SHR: r = a>>1; carry = a[0].
  - 8 AND, 9 OR, 11 NAND, 12 NOR, 13 XOR, 14 XNOR: bitwise on W bits; carry = 0.
  - 10 INV: ~a; carry = 0.
  - 15 BUF: a; carry = 0.
- div_err is cleared on every done that is not a DIV-by-zero.
- zero is computed from the new result_reg value.
- Reset mid-ITER: aborts the op, no done pulse, all outputs return to their reset values.

Test Plan:
- WIDTH=8, oe=1, a=0xCE, b=0x9B, sweep opcodes 0..15 one per transaction. Required:
  - ADD → 0x0169, carry=1
  - SUB → 0x0033, carry=0
  - AND → 0x008A
  - XOR → 0x0055
  - SHL → 0x019C, carry=1
  - SHR → 0x0067, carry=0
  - INV → 0x0031
  - Each done pulses 1 cycle after start.
- WIDTH=8, MUL 0xCE×0x9B → d_out=0x7CBA; busy high 8 cycles; done on the 9th cycle after start; start pulses during busy ignored.
- WIDTH=8, DIV:
  - 0xCE/0x9B → 0x3301.
  - 0x05/0x00 → 0x05FF, div_err=1, latency 1.
  - Next ADD 0x00+0x00 → 0x0000, zero=1, div_err=0.
- WIDTH=8, assert rst at the 4th busy cycle of a MUL → all outputs 0 immediately, no done; a new MUL after release completes correctly.
- WIDTH=16:
  - MUL 0xFFFF×0xFFFF → 0xFFFE0001 after 16 busy cycles.
  - DEC 0x0000 → 0x0001FFFF, carry=1.
- oe toggled low after a done → d_out=0, result_reg retained; oe high again → previous result reappears unchanged.

Source files
------------

// File: rtl/alu_seq_param.sv
// Registered, parametrised 16-opcode ALU with a start/busy/done handshake.
// MUL (shift-add) and DIV (restoring) iterate one bit per cycle; all other ops finish in one cycle.
module alu_seq_param #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         command_in,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic               oe,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] d_out,
  output logic               zero,
  output logic               carry,
  output logic               div_err
);

  localparam int CNTW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

  // state | meaning
  // IDLE  | waiting for start; latches opcode and operands
  // ITER  | MUL/DIV iterating, one bit per cycle
  // FIN   | result and flags written, done pulsed
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_INC  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_DEC  = 4'd3;
  localparam logic [3:0] OP_MUL  = 4'd4;
  localparam logic [3:0] OP_DIV  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_OR   = 4'd9;
  localparam logic [3:0] OP_INV  = 4'd10;
  localparam logic [3:0] OP_NAND = 4'd11;
  localparam logic [3:0] OP_NOR  = 4'd12;
  localparam logic [3:0] OP_XOR  = 4'd13;
  localparam logic [3:0] OP_XNOR = 4'd14;
  localparam logic [3:0] OP_BUF  = 4'd15;

  logic [1:0]         state_q, state_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [3:0]         cmd_q, cmd_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic               div_err_q, div_err_d;
  logic               busy_q, done_q;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_rem;
  logic [WIDTH-1:0]   div_sub;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;

  logic [WIDTH:0]     add_r, inc_r, sub_r, dec_r;
  logic [2*WIDTH-1:0] fin_res;
  logic               fin_carry, fin_err;

  // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    div_rem  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge   = (div_rem >= {1'b0, b_q});
    div_sub  = div_rem[WIDTH-1:0] - b_q;
    div_next = {(div_ge ? div_sub : div_rem[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
  end

  always_comb begin
    add_r     = {1'b0, a_q} + {1'b0, b_q};
    inc_r     = {1'b0, a_q} + (WIDTH+1)'(1);
    sub_r     = {1'b0, a_q} - {1'b0, b_q};
    dec_r     = {1'b0, a_q} - (WIDTH+1)'(1);
    fin_res   = '0;
    fin_carry = 1'b0;
    fin_err   = 1'b0;
    case (cmd_q)
      OP_ADD:  begin fin_res[WIDTH:0] = add_r; fin_carry = add_r[WIDTH]; end
      OP_INC:  begin fin_res[WIDTH:0] = inc_r; fin_carry = inc_r[WIDTH]; end
      OP_SUB:  begin fin_res[WIDTH:0] = sub_r; fin_carry = sub_r[WIDTH]; end
      OP_DEC:  begin fin_res[WIDTH:0] = dec_r; fin_carry = dec_r[WIDTH]; end
      OP_MUL:  fin_res = acc_q;
      OP_DIV: begin
        if (b_q == '0) begin
          fin_res = {a_q, {WIDTH{1'b1}}};
          fin_err = 1'b1;
        end else begin
          fin_res = acc_q;
        end
      end
      OP_SHL:  begin fin_res[WIDTH:0] = {a_q, 1'b0}; fin_carry = a_q[WIDTH-1]; end
      OP_SHR:  begin fin_res[WIDTH-1:0] = a_q >> 1; fin_carry = a_q[0]; end
      OP_AND:  fin_res[WIDTH-1:0] = a_q & b_q;
      OP_OR:   fin_res[WIDTH-1:0] = a_q | b_q;
      OP_INV:  fin_res[WIDTH-1:0] = ~a_q;
      OP_NAND: fin_res[WIDTH-1:0] = ~(a_q & b_q);
      OP_NOR:  fin_res[WIDTH-1:0] = ~(a_q | b_q);
      OP_XOR:  fin_res[WIDTH-1:0] = a_q ^ b_q;
      OP_XNOR: fin_res[WIDTH-1:0] = ~(a_q ^ b_q);
      default: fin_res[WIDTH-1:0] = a_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    result_d  = result_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    div_err_d = div_err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cmd_d = command_in;
          a_d   = a_in;
          b_d   = b_in;
          cnt_d = '0;
          if (command_in == OP_MUL) begin
            acc_d   = {{WIDTH{1'b0}}, b_in};
            state_d = S_ITER;
          end else if (command_in == OP_DIV && b_in != '0) begin
            acc_d   = {{WIDTH{1'b0}}, a_in};
            state_d = S_ITER;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_ITER: begin
        acc_d = (cmd_q == OP_MUL) ? mul_next : div_next;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FIN: begin
        result_d  = fin_res;
        zero_d    = (fin_res == '0);
        carry_d   = fin_carry;
        div_err_d = fin_err;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cmd_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      div_err_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      div_err_q <= div_err_d;
      busy_q    <= (state_q == S_ITER);
      done_q    <= (state_q == S_FIN);
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign d_out   = oe ? result_q : '0;
  assign zero    = zero_q;
  assign carry   = carry_q;
  assign div_err = div_err_q;

endmodule

// File: tb/tb_alu_seq_param.sv
// Directed plus randomised checks of alu_seq_param at WIDTH=8 and WIDTH=16 against an arithmetic reference model.
module tb_alu_seq_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst8, start8, oe8, busy8, done8, zero8, carry8, err8;
  logic [3:0]  cmd8;
  logic [7:0]  a8, b8;
  logic [15:0] dout8;

  logic        rst16, start16, oe16, busy16, done16, zero16, carry16, err16;
  logic [3:0]  cmd16;
  logic [15:0] a16, b16;
  logic [31:0] dout16;

  int tests = 0;
  int fails = 0;

  alu_seq_param #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .command_in(cmd8), .a_in(a8), .b_in(b8),
    .oe(oe8), .busy(busy8), .done(done8), .d_out(dout8), .zero(zero8), .carry(carry8),
    .div_err(err8)
  );

  alu_seq_param #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst16), .start(start16), .command_in(cmd16), .a_in(a16), .b_in(b16),
    .oe(oe16), .busy(busy16), .done(done16), .d_out(dout16), .zero(zero16), .carry(carry16),
    .div_err(err16)
  );

  task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference results from plain arithmetic on the operand values.
  function automatic void model(input int w, input logic [3:0] cmd, input longint unsigned a,
                                input longint unsigned b, output longint unsigned r,
                                output bit c, output bit e);
    longint unsigned mask = (64'd1 << w) - 1;
    bit brw;
    r = 0; c = 0; e = 0;
    case (cmd)
      4'd0:  begin r = a + b; c = r[w]; end
      4'd1:  begin r = a + 1; c = r[w]; end
      4'd2:  begin brw = (a < b);  r = ((a - b) & mask) | (longint'(brw) << w); c = brw; end
      4'd3:  begin brw = (a == 0); r = ((a - 1) & mask) | (longint'(brw) << w); c = brw; end
      4'd4:  r = a * b;
      4'd5:  if (b == 0) begin r = (a << w) | mask; e = 1; end
             else r = ((a % b) << w) | (a / b);
      4'd6:  begin r = a << 1; c = a[w-1]; end
      4'd7:  begin r = a >> 1; c = a[0]; end
      4'd8:  r = a & b;
      4'd9:  r = a | b;
      4'd10: r = ~a & mask;
      4'd11: r = ~(a & b) & mask;
      4'd12: r = ~(a | b) & mask;
      4'd13: r = a ^ b;
      4'd14: r = ~(a ^ b) & mask;
      default: r = a;
    endcase
  endfunction

  function automatic longint unsigned obs_dout(input int w);
    return (w == 8) ? longint'(dout8) : longint'(dout16);
  endfunction

  function automatic logic obs_busy(input int w);
    return (w == 8) ? busy8 : busy16;
  endfunction

  function automatic logic obs_done(input int w);
    return (w == 8) ? done8 : done16;
  endfunction

  // One transaction: start at a negedge, count cycles to done, then compare result and flags.
  task automatic txn(input int w, input logic [3:0] cmd, input logic [31:0] a,
                     input logic [31:0] b, input bit poke);
    longint unsigned er;
    bit ec, ee, iter, seen;
    int lat, k;
    string t;
    model(w, cmd, longint'(w == 8 ? {24'd0, a[7:0]} : {16'd0, a[15:0]}),
          longint'(w == 8 ? {24'd0, b[7:0]} : {16'd0, b[15:0]}), er, ec, ee);
    iter = (cmd == 4'd4) || (cmd == 4'd5 && (w == 8 ? b[7:0] != 0 : b[15:0] != 0));
    lat  = iter ? w + 1 : 1;
    t = $sformatf("w%0d op%0d a=%0h b=%0h", w, cmd, a, b);
    @(negedge clk);
    if (w == 8) begin start8 = 1; cmd8 = cmd; a8 = a[7:0]; b8 = b[7:0]; end
    else begin start16 = 1; cmd16 = cmd; a16 = a[15:0]; b16 = b[15:0]; end
    @(posedge clk); #1;
    start8 = 0; start16 = 0;
    seen = 0; k = 0;
    while (!seen && k < w + 4) begin
      @(posedge clk); #1; k++;
      if (poke && k == 3) begin start8 = 1; cmd8 = 4'd0; a8 = ~a8; b8 = ~b8; end
      if (poke && k == 4) start8 = 0;
      if (obs_done(w)) seen = 1;
      else chk({t, " busy"}, longint'(obs_busy(w)), longint'(iter));
    end
    chk({t, " latency"}, longint'(k), longint'(lat));
    chk({t, " busy@done"}, longint'(obs_busy(w)), 0);
    chk({t, " d_out"}, obs_dout(w), er);
    chk({t, " carry"}, longint'(w == 8 ? carry8 : carry16), longint'(ec));
    chk({t, " zero"}, longint'(w == 8 ? zero8 : zero16), longint'(er == 0));
    chk({t, " div_err"}, longint'(w == 8 ? err8 : err16), longint'(ee));
    if (poke) begin
      repeat (3) begin
        @(posedge clk); #1;
        chk({t, " no done after ignored start"}, longint'(done8), 0);
      end
    end
  endtask

  initial begin
    rst8 = 1; rst16 = 1; start8 = 0; start16 = 0; oe8 = 1; oe16 = 1;
    cmd8 = 0; a8 = 0; b8 = 0; cmd16 = 0; a16 = 0; b16 = 0;
    #12;
    chk("reset busy", longint'(busy8), 0);
    chk("reset done", longint'(done8), 0);
    chk("reset d_out", longint'(dout8), 0);
    chk("reset zero", longint'(zero8), 0);
    chk("reset carry", longint'(carry8), 0);
    chk("reset div_err", longint'(err8), 0);
    @(negedge clk); rst8 = 0; rst16 = 0;

    // Opcode sweep with the reference operands; literal expectations for the listed ops.
    for (int op = 0; op < 16; op++) begin
      txn(8, 4'(op), 32'hCE, 32'h9B, 1'b0);
      case (op)
        0:  chk("ADD literal", longint'(dout8), 64'h0169);
        2:  chk("SUB literal", longint'(dout8), 64'h0033);
        4:  chk("MUL literal", longint'(dout8), 64'h7CBA);
        5:  chk("DIV literal", longint'(dout8), 64'h3301);
        6:  chk("SHL literal", longint'(dout8), 64'h019C);
        7:  chk("SHR literal", longint'(dout8), 64'h0067);
        8:  chk("AND literal", longint'(dout8), 64'h008A);
        10: chk("INV literal", longint'(dout8), 64'h0031);
        13: chk("XOR literal", longint'(dout8), 64'h0055);
        default: ;
      endcase
    end

    txn(8, 4'd4, 32'hCE, 32'h9B, 1'b1);
    chk("MUL with ignored starts", longint'(dout8), 64'h7CBA);
    txn(8, 4'd5, 32'h05, 32'h00, 1'b0);
    chk("DIV by zero literal", longint'(dout8), 64'h05FF);
    txn(8, 4'd0, 32'h00, 32'h00, 1'b0);
    chk("ADD zero clears div_err", longint'(err8), 0);

    // Reset on the fourth busy cycle of a MUL.
    @(negedge clk); start8 = 1; cmd8 = 4'd4; a8 = 8'hCE; b8 = 8'h9B;
    @(posedge clk); #1; start8 = 0;
    repeat (4) begin @(posedge clk); #1; end
    chk("busy before abort", longint'(busy8), 1);
    rst8 = 1; #1;
    chk("abort busy", longint'(busy8), 0);
    chk("abort done", longint'(done8), 0);
    chk("abort d_out", longint'(dout8), 0);
    chk("abort flags", longint'({zero8, carry8, err8}), 0);
    repeat (3) begin @(posedge clk); #1; chk("no done in reset", longint'(done8), 0); end
    @(negedge clk); rst8 = 0;
    repeat (12) begin @(posedge clk); #1; chk("no done after abort", longint'(done8), 0); end
    txn(8, 4'd4, 32'hCE, 32'h9B, 1'b0);
    chk("MUL after abort", longint'(dout8), 64'h7CBA);

    txn(16, 4'd4, 32'hFFFF, 32'hFFFF, 1'b0);
    chk("MUL16 literal", longint'(dout16), 64'hFFFE0001);
    txn(16, 4'd3, 32'h0000, 32'h0000, 1'b0);
    chk("DEC16 literal", longint'(dout16), 64'h0001FFFF);
    chk("DEC16 carry", longint'(carry16), 1);

    // Output enable gating keeps the stored result.
    txn(8, 4'd13, 32'hCE, 32'h9B, 1'b0);
    @(negedge clk); oe8 = 0; #1;
    chk("oe low d_out", longint'(dout8), 0);
    repeat (3) @(posedge clk);
    @(negedge clk); oe8 = 1; #1;
    chk("oe high d_out", longint'(dout8), 64'h0055);

    for (int i = 0; i < 40; i++) begin
      txn(8, 4'($urandom_range(15)), $urandom, ($urandom_range(7) == 0) ? 32'd0 : $urandom, 1'b0);
      txn(16, 4'($urandom_range(15)), $urandom, ($urandom_range(7) == 0) ? 32'd0 : $urandom, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
